// File: rtl/axi_rx_pkg.sv
// Shared types and byte-lane helpers for the AXI-Stream RX packer.
// Helpers work on a maximum width; callers size-cast in and out.
package axi_rx_pkg;

  localparam int DW_MAX = 512;
  localparam int NB_MAX = DW_MAX / 8;

  typedef enum logic {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Move kept byte lanes down to the lowest lanes, ascending lane order.
  // Lanes above the kept count are zero.
  function automatic logic [DW_MAX-1:0] compact_bytes(input logic [DW_MAX-1:0] data,
                                                      input logic [NB_MAX-1:0] keep);
    logic [DW_MAX-1:0] res;
    int unsigned       k;
    res = '0;
    k   = 0;
    for (int i = 0; i < NB_MAX; i++) begin
      if (keep[i]) begin
        res[8*k +: 8] = data[8*i +: 8];
        k++;
      end
    end
    return res;
  endfunction

  // Number of set keep bits.
  function automatic int unsigned popcount(input logic [NB_MAX-1:0] keep);
    int unsigned n;
    n = 0;
    for (int i = 0; i < NB_MAX; i++) n += int'(keep[i]);
    return n;
  endfunction

endpackage

// File: rtl/axi_rx_fifo.sv
// Small synchronous FIFO; head entry is presented combinationally.
module axi_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wptr_q, rptr_q;
  logic [AW:0]                 cnt_q;
  logic                        do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  // Storage, pointers and occupancy; simultaneous push/pop keeps occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/axi_rx_packer.sv
// AXI-Stream ingress packer: compacts sparse tkeep beats and, in pack mode,
// merges bytes across beats into full words before an output FIFO.
module axi_rx_packer
  import axi_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int PACK_MODE  = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  s_tvalid,
  input  logic [DATA_WIDTH-1:0]                 s_tdata,
  input  logic [DATA_WIDTH/8-1:0]               s_tkeep,
  input  logic                                  s_tlast,
  output logic                                  s_tready,
  output logic                                  m_valid,
  output logic [DATA_WIDTH-1:0]                 m_data,
  output logic [$clog2(DATA_WIDTH/8+1)-1:0]     m_count,
  output logic                                  m_last,
  input  logic                                  m_ready,
  output logic [31:0]                           pkt_count
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = $clog2(NB + 1);
  localparam int EW = DATA_WIDTH + CW + 1;
  localparam logic [CW:0] NB_W = (CW+1)'(NB);

  state_e                  state_q, state_d;
  logic                    ready_en_q;
  logic [DATA_WIDTH-1:0]   acc_data_q, acc_data_d;
  logic [CW-1:0]           acc_cnt_q, acc_cnt_d;
  logic [31:0]             pkt_cnt_q;

  logic                    fifo_full, fifo_empty, pop, accept;
  logic                    push, push_last;
  logic [CW-1:0]           push_cnt;
  logic [DATA_WIDTH-1:0]   push_data;
  logic [EW-1:0]           head_entry;

  logic [DATA_WIDTH-1:0]   comp;
  logic [CW-1:0]           cnt;
  logic [CW:0]             total;
  logic [2*DATA_WIDTH-1:0] merged;

  // Ready depends only on registered state, never on m_ready.
  assign s_tready = ready_en_q && !fifo_full && (state_q == ACCUM);
  assign accept   = s_tvalid && s_tready;

  assign comp   = DATA_WIDTH'(compact_bytes(DW_MAX'(s_tdata), NB_MAX'(s_tkeep)));
  assign cnt    = CW'(popcount(NB_MAX'(s_tkeep)));
  assign total  = (CW+1)'(acc_cnt_q) + (CW+1)'(cnt);
  // New bytes land right after the residual bytes; the upper word is the remainder.
  assign merged = {{DATA_WIDTH{1'b0}}, acc_data_q}
                | ({{DATA_WIDTH{1'b0}}, comp} << {acc_cnt_q, 3'b000});

  // Decide what to push and how the accumulator/state evolve this cycle.
  always_comb begin
    push       = 1'b0;
    push_data  = '0;
    push_cnt   = '0;
    push_last  = 1'b0;
    acc_data_d = acc_data_q;
    acc_cnt_d  = acc_cnt_q;
    state_d    = state_q;
    if (state_q == FLUSH) begin
      if (!fifo_full) begin
        push       = 1'b1;
        push_data  = acc_data_q;
        push_cnt   = acc_cnt_q;
        push_last  = 1'b1;
        acc_data_d = '0;
        acc_cnt_d  = '0;
        state_d    = ACCUM;
      end
    end else if (accept) begin
      if (PACK_MODE == 0) begin
        push      = (cnt != '0) || s_tlast;
        push_data = comp;
        push_cnt  = cnt;
        push_last = s_tlast;
      end else if (s_tlast && (total <= NB_W)) begin
        push       = 1'b1;
        push_data  = merged[DATA_WIDTH-1:0];
        push_cnt   = CW'(total);
        push_last  = 1'b1;
        acc_data_d = '0;
        acc_cnt_d  = '0;
      end else if (total >= NB_W) begin
        // Full word out; leftover bytes stay. A tlast here needs a flush cycle.
        push       = 1'b1;
        push_data  = merged[DATA_WIDTH-1:0];
        push_cnt   = CW'(NB);
        acc_data_d = merged[2*DATA_WIDTH-1:DATA_WIDTH];
        acc_cnt_d  = CW'(total - NB_W);
        if (s_tlast) state_d = FLUSH;
      end else begin
        acc_data_d = merged[DATA_WIDTH-1:0];
        acc_cnt_d  = CW'(total);
      end
    end
  end

  // FSM, accumulator and ready-enable registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      ready_en_q <= 1'b0;
      acc_data_q <= '0;
      acc_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      acc_data_q <= acc_data_d;
      acc_cnt_q  <= acc_cnt_d;
    end
  end

  axi_rx_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .wdata_i({push_last, push_cnt, push_data}),
    .pop_i  (pop),
    .rdata_o(head_entry),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign {m_last, m_count, m_data} = m_valid ? head_entry : '0;

  // Delivered-packet counter, wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                pkt_cnt_q <= '0;
    else if (pop && m_last)    pkt_cnt_q <= pkt_cnt_q + 32'd1;
  end

  assign pkt_count = pkt_cnt_q;

endmodule
